// File: rtl/gat_layer_sequencer.sv
// rtl/gat_layer_sequencer.sv - GAT core layer sequencer with feature BRAM drain to stream
module gat_layer_sequencer #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int FEAT_WORDS         = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(FEAT_WORDS),
  parameter int TIMEOUT_CYCLES     = 2**24 - 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            cfg_two_layers,
  input  logic                            h_data_loaded,
  input  logic                            h_node_info_loaded,
  input  logic                            wgt_loaded,
  output logic                            h_data_bram_load_done,
  output logic                            h_node_info_bram_load_done,
  output logic                            wgt_bram_load_done,
  output logic                            gat_layer,
  input  logic                            gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]    m_tdata,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  input  logic                            m_tready,
  output logic                            reload_req,
  output logic                            busy,
  output logic                            done,
  output logic                            err_timeout
);

  localparam int AW    = NEW_FEATURE_ADDR_W;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0]    LAST_WORD = AW'(FEAT_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOAD, S_RUN, S_WAIT_READY, S_DRAIN, S_RELOAD
  } state_t;

  state_t            state_q, state_d;
  logic              layer_q, layer_d;
  logic              two_q, two_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              load_done_q, load_done_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [AW-1:0]     word_addr_q, word_addr_d;
  logic              issue_done_q, issue_done_d;
  logic [AW-1:0]     beat_q, beat_d;
  logic [2:0]        seen_low_q, seen_low_d;

  logic [NEW_FEATURE_WIDTH-1:0] buf_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              pend_q;

  logic [2:0]        loaded_vec;
  logic              all_loaded;
  logic [1:0]        occ;
  logic              pop;
  logic              issue;

  assign loaded_vec = {h_data_loaded, h_node_info_loaded, wgt_loaded};
  assign all_loaded = &loaded_vec;

  // Credit check counts the beat leaving this cycle so a full buffer still streams 1 beat/cycle.
  assign occ   = cnt_q + {1'b0, pend_q};
  assign pop   = m_tvalid && m_tready;
  assign issue = (state_q == S_DRAIN) && !issue_done_q && ((occ < 2'd2) || pop);

  assign m_tvalid = (cnt_q != 2'd0);
  assign m_tdata  = buf_q[rd_ptr_q];
  assign m_tlast  = m_tvalid && (beat_q == LAST_WORD);

  assign h_data_bram_load_done      = load_done_q;
  assign h_node_info_bram_load_done = load_done_q;
  assign wgt_bram_load_done         = load_done_q;
  assign gat_layer       = layer_q;
  assign feat_bram_addrb = {word_addr_q, 2'b00};
  assign reload_req      = (state_q == S_RELOAD);
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign err_timeout     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      layer_q      <= 1'b0;
      two_q        <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      load_done_q  <= 1'b0;
      tmo_q        <= '0;
      word_addr_q  <= '0;
      issue_done_q <= 1'b0;
      beat_q       <= '0;
      seen_low_q   <= '0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      two_q        <= two_d;
      err_q        <= err_d;
      done_q       <= done_d;
      load_done_q  <= load_done_d;
      tmo_q        <= tmo_d;
      word_addr_q  <= word_addr_d;
      issue_done_q <= issue_done_d;
      beat_q       <= beat_d;
      seen_low_q   <= seen_low_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    two_d        = two_q;
    err_d        = err_q;
    done_d       = 1'b0;
    load_done_d  = load_done_q;
    tmo_d        = tmo_q;
    word_addr_d  = word_addr_q;
    issue_done_d = issue_done_q;
    beat_d       = beat_q;
    seen_low_d   = seen_low_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          two_d   = cfg_two_layers;
          layer_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_WAIT_LOAD;
        end
      end
      S_WAIT_LOAD: begin
        if (all_loaded) state_d = S_RUN;
      end
      S_RUN: begin
        load_done_d = 1'b1;
        tmo_d       = '0;
        state_d     = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        if (gat_ready) begin
          state_d      = S_DRAIN;
          word_addr_d  = '0;
          issue_done_d = 1'b0;
          beat_d       = '0;
        end else if (tmo_q == TMO_LAST) begin
          err_d       = 1'b1;
          load_done_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (issue) begin
          if (word_addr_q == LAST_WORD) issue_done_d = 1'b1;
          else                          word_addr_d  = word_addr_q + 1'b1;
        end
        if (pop) begin
          if (beat_q == LAST_WORD) begin
            load_done_d = 1'b0;
            if (!layer_q && two_q) begin
              seen_low_d = '0;
              state_d    = S_RELOAD;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_RELOAD: begin
        // Each flag must have dropped at least once so a stale "loaded" is not mistaken for a reload.
        seen_low_d = seen_low_q | ~loaded_vec;
        if ((&seen_low_q) && all_loaded) begin
          layer_d = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      pend_q <= issue;
      if (pend_q) begin
        buf_q[wr_ptr_q] <= feat_bram_dout;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({pend_q, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_gat_layer_sequencer.sv
// tb/tb_gat_layer_sequencer.sv - scoreboard bench for gat_layer_sequencer
module tb_gat_layer_sequencer;
  localparam int W   = 32;
  localparam int NSG = 8;
  localparam int NFO = 16;
  localparam int FW  = NSG * NFO;
  localparam int AW  = $clog2(FW);
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, cfg_two_layers = 1'b0;
  logic h_data_loaded = 1'b0, h_node_info_loaded = 1'b0, wgt_loaded = 1'b0;
  logic h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done;
  logic gat_layer;
  logic gat_ready = 1'b0;
  logic [AW+1:0] feat_bram_addrb;
  logic [W-1:0]  feat_bram_dout = '0;
  logic [W-1:0]  m_tdata;
  logic m_tvalid, m_tlast;
  logic m_tready = 1'b1;
  logic reload_req, busy, done, err_timeout;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0;
  int done_cnt = 0, acc_cnt = 0;
  logic [W-1:0] bram_seed = '0;
  logic bp_en = 1'b0;

  gat_layer_sequencer #(
    .NEW_FEATURE_WIDTH(W), .NUM_SUBGRAPHS(NSG), .NUM_FEATURE_OUT(NFO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_two_layers(cfg_two_layers),
    .h_data_loaded(h_data_loaded), .h_node_info_loaded(h_node_info_loaded), .wgt_loaded(wgt_loaded),
    .h_data_bram_load_done(h_data_bram_load_done),
    .h_node_info_bram_load_done(h_node_info_bram_load_done),
    .wgt_bram_load_done(wgt_bram_load_done),
    .gat_layer(gat_layer), .gat_ready(gat_ready),
    .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .reload_req(reload_req), .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word_of(input logic [W-1:0] seed, input int i);
    return seed ^ (32'(i) * 32'h9E37_79B1);
  endfunction

  // BRAM model: one-cycle read latency on the word part of the byte address.
  always @(posedge clk) feat_bram_dout <= word_of(bram_seed, int'(feat_bram_addrb[AW+1:2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic prev_stall;
    logic [W-1:0] prev_d;
    logic prev_l;
    exp_t e;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (busy) check("addr_align", 64'(feat_bram_addrb[1:0]), 64'd0);
        if (prev_stall) begin
          check("stall_valid", 64'(m_tvalid), 64'd1);
          check("stall_data", 64'(m_tdata), 64'(prev_d));
          check("stall_last", 64'(m_tlast), 64'(prev_l));
        end
        if (m_tvalid && m_tready) begin
          check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("beat_data", 64'(m_tdata), 64'(e.d));
            check("beat_last", 64'(m_tlast), 64'(e.l));
          end
          acc_cnt++;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_d = m_tdata;
        prev_l = m_tlast;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) m_tready = ($urandom_range(0, 99) < 30);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_loaded(input logic v);
    h_data_loaded = v;
    h_node_info_loaded = v;
    wgt_loaded = v;
  endtask

  task automatic pulse_start(input logic two);
    cfg_two_layers = two;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_load_done(input string nm);
    int n = 0;
    while (!h_data_bram_load_done && n < 200) begin
      tick();
      n++;
    end
    check(nm, 64'(h_data_bram_load_done), 64'd1);
  endtask

  task automatic start_drain(input logic [W-1:0] seed);
    exp_t e;
    bram_seed = seed;
    for (int i = 0; i < FW; i++) begin
      e.d = word_of(seed, i);
      e.l = (i == FW - 1);
      exp_q.push_back(e);
    end
    gat_ready = 1'b1;
    tick();
    check("drain_addr0", 64'(feat_bram_addrb), 64'd0);
    check("tvalid_e1", 64'(m_tvalid), 64'd0);
    tick();
    check("tvalid_e2", 64'(m_tvalid), 64'd0);
    tick();
    check("tvalid_e3", 64'(m_tvalid), 64'd1);
  endtask

  task automatic wait_exit(output int n);
    n = 0;
    while (!done && !reload_req && n < 5000) begin
      tick();
      n++;
    end
    check("drain_exit", 64'(done || reload_req), 64'd1);
  endtask

  initial begin
    int n, d0, a0;

    // Reset state
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_addr", 64'(feat_bram_addrb), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err_timeout), 64'd0);
    check("rst_layer", 64'(gat_layer), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single layer at full rate
    set_loaded(1'b1);
    m_tready = 1'b1;
    d0 = done_cnt;
    pulse_start(1'b0);
    check("s1_busy", 64'(busy), 64'd1);
    check("s1_ld_waitload", 64'(wgt_bram_load_done), 64'd0);
    tick();
    check("s1_ld_run", 64'(h_node_info_bram_load_done), 64'd0);
    tick();
    check("s1_ld_ready", 64'(h_data_bram_load_done), 64'd1);
    repeat (20) tick();
    start_drain(32'h1000_0000);
    wait_exit(n);
    check("s1_cycles", 64'(n), 64'(FW));
    check("s1_done", 64'(done), 64'd1);
    check("s1_layer", 64'(gat_layer), 64'd0);
    gat_ready = 1'b0;
    tick();
    check("s1_idle", 64'(busy), 64'd0);
    check("s1_done_once", 64'(done_cnt - d0), 64'd1);
    check("s1_sb_empty", 64'(exp_q.size()), 64'd0);

    // Two layers with host reload
    d0 = done_cnt;
    pulse_start(1'b1);
    wait_load_done("t2_ld0");
    repeat (5) tick();
    start_drain(32'h2222_0000);
    wait_exit(n);
    check("t2_reload", 64'(reload_req), 64'd1);
    check("t2_cycles0", 64'(n), 64'(FW));
    check("t2_ld_low", 64'(wgt_bram_load_done), 64'd0);
    check("t2_no_done0", 64'(done), 64'd0);
    check("t2_layer0", 64'(gat_layer), 64'd0);
    gat_ready = 1'b0;
    tick();
    check("t2_reload_hold", 64'(reload_req), 64'd1);
    set_loaded(1'b0);
    repeat (3) tick();
    check("t2_reload_low", 64'(reload_req), 64'd1);
    bram_seed = 32'h3333_0000;
    h_data_loaded = 1'b1;
    tick();
    check("t2_reload_partial", 64'(reload_req), 64'd1);
    h_node_info_loaded = 1'b1;
    wgt_loaded = 1'b1;
    wait_load_done("t2_ld1");
    check("t2_layer1", 64'(gat_layer), 64'd1);
    check("t2_reload_off", 64'(reload_req), 64'd0);
    check("t2_no_mid_done", 64'(done_cnt - d0), 64'd0);
    start_drain(32'h3333_0000);
    wait_exit(n);
    check("t2_cycles1", 64'(n), 64'(FW));
    check("t2_done", 64'(done), 64'd1);
    check("t2_layer1_end", 64'(gat_layer), 64'd1);
    gat_ready = 1'b0;
    tick();
    check("t2_done_once", 64'(done_cnt - d0), 64'd1);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure, start while busy, loaded drop ignored
    d0 = done_cnt;
    pulse_start(1'b0);
    wait_load_done("t3_ld");
    h_data_loaded = 1'b0;
    wgt_loaded = 1'b0;
    pulse_start(1'b1);
    repeat (5) tick();
    check("t3_busy", 64'(busy), 64'd1);
    check("t3_ld_kept", 64'(h_data_bram_load_done), 64'd1);
    check("t3_layer", 64'(gat_layer), 64'd0);
    bp_en = 1'b1;
    start_drain(32'h4444_0000);
    wait_exit(n);
    check("t3_done", 64'(done), 64'd1);
    check("t3_no_reload", 64'(reload_req), 64'd0);
    bp_en = 1'b0;
    m_tready = 1'b1;
    gat_ready = 1'b0;
    set_loaded(1'b1);
    tick();
    check("t3_done_once", 64'(done_cnt - d0), 64'd1);
    check("t3_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t3_idle", 64'(busy), 64'd0);

    // Timeout in WAIT_READY
    d0 = done_cnt;
    pulse_start(1'b0);
    wait_load_done("t4_ld");
    repeat (TMO - 1) tick();
    check("t4_err_early", 64'(err_timeout), 64'd0);
    check("t4_busy_early", 64'(busy), 64'd1);
    tick();
    check("t4_err", 64'(err_timeout), 64'd1);
    check("t4_idle", 64'(busy), 64'd0);
    repeat (3) tick();
    check("t4_err_sticky", 64'(err_timeout), 64'd1);
    check("t4_no_done", 64'(done_cnt - d0), 64'd0);
    pulse_start(1'b0);
    check("t4_err_cleared", 64'(err_timeout), 64'd0);

    // Reset in the middle of a drain
    wait_load_done("t5_ld");
    a0 = acc_cnt;
    start_drain(32'h5555_0000);
    n = 0;
    while (acc_cnt < a0 + 50 && n < 500) begin
      tick();
      n++;
    end
    check("t5_reach_50", 64'(acc_cnt >= a0 + 50), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_tvalid", 64'(m_tvalid), 64'd0);
    check("t5_tdata", 64'(m_tdata), 64'd0);
    check("t5_tlast", 64'(m_tlast), 64'd0);
    check("t5_addr", 64'(feat_bram_addrb), 64'd0);
    check("t5_ld", 64'(wgt_bram_load_done), 64'd0);
    check("t5_layer", 64'(gat_layer), 64'd0);
    exp_q.delete();
    gat_ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("t5_stay_idle", 64'(busy), 64'd0);
    check("t5_no_valid", 64'(m_tvalid), 64'd0);
    d0 = done_cnt;
    pulse_start(1'b0);
    wait_load_done("t5_ld2");
    repeat (3) tick();
    start_drain(32'h6666_0000);
    wait_exit(n);
    check("t5_cycles", 64'(n), 64'(FW));
    check("t5_done", 64'(done), 64'd1);
    gat_ready = 1'b0;
    tick();
    check("t5_done_once", 64'(done_cnt - d0), 64'd1);
    check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
